// File: rtl/pipelined_normalizer.sv
// Two-stage leading-zero normalizer with valid/ready on both sides.
// Define NORMALIZER_DENORM_EN for gradual underflow; otherwise underflow flushes to zero.
module pipelined_normalizer #(
    parameter int unsigned MAN_WIDTH = 24,
    parameter int unsigned EXP_WIDTH = 8,
    localparam int unsigned LZC_WIDTH = $clog2(MAN_WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [MAN_WIDTH-1:0] in_sig,
    input  logic [EXP_WIDTH-1:0] in_exp,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [MAN_WIDTH-1:0] out_sig,
    output logic [EXP_WIDTH-1:0] out_exp,
    output logic                 out_zero,
    output logic                 out_underflow
);

    localparam int unsigned NUM_GROUPS = (MAN_WIDTH + 3) / 4;
    localparam int unsigned PAD_WIDTH  = NUM_GROUPS * 4;
    localparam int unsigned PAD_BITS   = PAD_WIDTH - MAN_WIDTH;

    function automatic logic [1:0] nib_lz(input logic [3:0] nib);
        casez (nib)
            4'b1???: nib_lz = 2'd0;
            4'b01??: nib_lz = 2'd1;
            4'b001?: nib_lz = 2'd2;
            default: nib_lz = 2'd3;
        endcase
    endfunction

    logic                 s1_valid, s2_valid;
    logic                 s1_adv, s2_adv;
    logic [MAN_WIDTH-1:0] s1_sig, s2_sig;
    logic [EXP_WIDTH-1:0] s1_exp, s2_exp;
    logic [LZC_WIDTH-1:0] s1_lzc;
    logic                 s1_zero, s2_zero, s2_uf;

    logic [PAD_WIDTH-1:0] padded;
    logic [1:0]           grp_lz   [NUM_GROUPS];
    logic                 grp_zero [NUM_GROUPS];
    logic [LZC_WIDTH-1:0] lzc;
    logic                 all_zero;

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // LSB padding keeps the MSB group aligned with the significand MSB
    assign padded = PAD_WIDTH'(in_sig) << PAD_BITS;

    always_comb begin
        for (int g = 0; g < int'(NUM_GROUPS); g++) begin
            grp_lz[g]   = nib_lz(padded[PAD_WIDTH-1-4*g -: 4]);
            grp_zero[g] = (padded[PAD_WIDTH-1-4*g -: 4] == 4'b0000);
        end
    end

    always_comb begin
        int unsigned cnt;
        logic        found;
        cnt   = 0;
        found = 1'b0;
        for (int g = 0; g < int'(NUM_GROUPS); g++) begin
            if (!found) begin
                if (grp_zero[g]) begin
                    cnt = cnt + 4;
                end else begin
                    cnt   = cnt + 32'(grp_lz[g]);
                    found = 1'b1;
                end
            end
        end
        // count is meaningless when all groups are zero; all_zero covers that case
        lzc      = LZC_WIDTH'(cnt);
        all_zero = !found;
    end

    logic                 uf;
    logic [MAN_WIDTH-1:0] nxt_sig;
    logic [EXP_WIDTH-1:0] nxt_exp;

    assign uf = !s1_zero && (32'(s1_exp) <= 32'(s1_lzc));

`ifdef NORMALIZER_DENORM_EN
    logic [EXP_WIDTH-1:0] dn_shift;
    assign dn_shift = (s1_exp == '0) ? '0 : s1_exp - EXP_WIDTH'(1);
`endif

    always_comb begin
        nxt_sig = s1_sig << s1_lzc;
        nxt_exp = s1_exp - EXP_WIDTH'(s1_lzc);
        if (s1_zero) begin
            nxt_sig = '0;
            nxt_exp = '0;
        end else if (uf) begin
            nxt_exp = '0;
`ifdef NORMALIZER_DENORM_EN
            nxt_sig = s1_sig << dn_shift;
`else
            nxt_sig = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_sig   <= '0;
            s1_exp   <= '0;
            s1_lzc   <= '0;
            s1_zero  <= 1'b0;
            s2_valid <= 1'b0;
            s2_sig   <= '0;
            s2_exp   <= '0;
            s2_zero  <= 1'b0;
            s2_uf    <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
            end
            if (s1_adv && in_valid) begin
                s1_sig  <= in_sig;
                s1_exp  <= in_exp;
                s1_lzc  <= lzc;
                s1_zero <= all_zero;
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
            end
            if (s2_adv && s1_valid) begin
                s2_sig  <= nxt_sig;
                s2_exp  <= nxt_exp;
                s2_zero <= s1_zero;
                s2_uf   <= uf;
            end
        end
    end

    assign out_valid     = s2_valid;
    assign out_sig       = s2_sig;
    assign out_exp       = s2_exp;
    assign out_zero      = s2_zero;
    assign out_underflow = s2_uf;

endmodule

// File: tb/tb_pipelined_normalizer.sv
// Scoreboard bench for pipelined_normalizer; honours NORMALIZER_DENORM_EN like the RTL.
module tb_pipelined_normalizer;

    localparam int MW = 24;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [MW-1:0] in_sig = '0;
    logic [EW-1:0] in_exp = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [MW-1:0] out_sig;
    logic [EW-1:0] out_exp;
    logic          out_zero;
    logic          out_underflow;

    pipelined_normalizer #(
        .MAN_WIDTH(MW),
        .EXP_WIDTH(EW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sig        (in_sig),
        .in_exp        (in_exp),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_sig       (out_sig),
        .out_exp       (out_exp),
        .out_zero      (out_zero),
        .out_underflow (out_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [MW-1:0] sig;
        logic [EW-1:0] exp;
        logic          zero;
        logic          uf;
        int            cyc;
        bit            lat;
    } res_t;

    res_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    bit   lat_check = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    endtask

    function automatic res_t model(input logic [MW-1:0] s, input logic [EW-1:0] e);
        res_t r;
        int   lz;
        r.sig  = '0;
        r.exp  = '0;
        r.zero = 1'b0;
        r.uf   = 1'b0;
        r.cyc  = 0;
        r.lat  = 1'b0;
        lz     = 0;
        if (s == '0) begin
            r.zero = 1'b1;
            return r;
        end
        for (int i = MW - 1; i >= 0; i--) begin
            if (s[i]) break;
            lz++;
        end
        if (int'(e) <= lz) begin
            r.uf = 1'b1;
`ifdef NORMALIZER_DENORM_EN
            r.sig = s << ((e == '0) ? 0 : int'(e) - 1);
`endif
        end else begin
            r.sig = s << lz;
            r.exp = e - EW'(lz);
        end
        return r;
    endfunction

    // One clock: drive after the edge, observe both handshakes at the falling edge.
    task automatic cycle(input logic v, input logic [MW-1:0] s, input logic [EW-1:0] e,
                         input logic ordy, output bit acc);
        res_t r;
        in_valid  = v;
        in_sig    = s;
        in_exp    = e;
        out_ready = ordy;
        @(negedge clk);
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 64'(out_valid), 64'd0);
            end else begin
                r = sb.pop_front();
                check("out_sig", 64'(out_sig), 64'(r.sig));
                check("out_exp", 64'(out_exp), 64'(r.exp));
                check("out_zero", 64'(out_zero), 64'(r.zero));
                check("out_underflow", 64'(out_underflow), 64'(r.uf));
                if (r.lat) check("latency", 64'(cyc - r.cyc), 64'd2);
            end
        end
        if (acc) begin
            r     = model(s, e);
            r.cyc = cyc;
            r.lat = lat_check;
            sb.push_back(r);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 20 && sb.size() > 0; i++) cycle(1'b0, '0, '0, 1'b1, acc);
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_sig"}, 64'(out_sig), 64'd0);
        check({tag, "_out_exp"}, 64'(out_exp), 64'd0);
        check({tag, "_flags"}, 64'({out_zero, out_underflow}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        res_t held;

        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Directed vectors with out_ready held high: fixed 2-cycle latency
        lat_check = 1'b1;
        cycle(1'b1, 24'h000800, 8'd100, 1'b1, acc);
        check("t1_acc", 64'(acc), 64'd1);
        drain();

        cycle(1'b1, 24'h800000, 8'd1, 1'b1, acc);
        check("t2_acc", 64'(acc), 64'd1);
        for (int i = 0; i < 24; i++) begin
            cycle(1'b1, 24'hFFFFFF >> i, EW'(2 * i), 1'b1, acc);
            check("b2b_acc", 64'(acc), 64'd1);
        end
        drain();

        cycle(1'b1, 24'h000000, 8'd77, 1'b1, acc);
        cycle(1'b1, 24'h000001, 8'd10, 1'b1, acc);
        cycle(1'b1, 24'h000003, 8'd0, 1'b1, acc);
        cycle(1'b1, 24'h0000F0, 8'd17, 1'b1, acc);
        drain();

        // Backpressure: two accepted, third refused, output held
        lat_check = 1'b0;
        cycle(1'b1, 24'h0000F0, 8'd50, 1'b0, acc);
        check("stall_acc1", 64'(acc), 64'd1);
        cycle(1'b1, 24'h001234, 8'd60, 1'b0, acc);
        check("stall_acc2", 64'(acc), 64'd1);
        held = sb[0];
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 24'h400000, 8'd5, 1'b0, acc);
            check("stall_in_ready", 64'(acc), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_hold_sig", 64'(out_sig), 64'(held.sig));
            check("stall_hold_exp", 64'(out_exp), 64'(held.exp));
        end
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) cycle(1'b1, 24'h400000, 8'd5, 1'b1, acc);
        check("stall_release_acc", 64'(acc), 64'd1);
        drain();

        // Reset with two operands in flight
        cycle(1'b1, 24'h00ABCD, 8'd40, 1'b0, acc);
        cycle(1'b1, 24'h0F0000, 8'd41, 1'b0, acc);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_idle_outputs("async_reset");
        sb.delete();
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("post_reset_in_ready", 64'(in_ready), 64'd1);
        lat_check = 1'b1;
        cycle(1'b1, 24'h000400, 8'd30, 1'b1, acc);
        cycle(1'b1, 24'h000000, 8'd9, 1'b1, acc);
        drain();

        // Random traffic with random backpressure
        lat_check = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 3) != 0,
                  MW'(($urandom & 32'hFFFFFF) >> $urandom_range(0, 24)),
                  EW'($urandom_range(0, 40)),
                  $urandom_range(0, 3) != 0, acc);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
